// File: rtl/marker_pkg.sv
// rtl/marker_pkg.sv - shared widths, state encoding and beat record for the marker frame sequencer
//
// Contents:
//   calc_xw / calc_yw : pixel-counter widths from screen dimensions
//   acq_state_e       : acquisition FSM states
//   target_beat_t     : one streamed target, fields sized for the largest supported geometry
package marker_pkg;

    function automatic int calc_xw(input int screen_width);
        return $clog2(screen_width);
    endfunction

    function automatic int calc_yw(input int screen_height);
        return $clog2(screen_height) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_SNAPSHOT = 2'd3
    } acq_state_e;

    localparam int BEAT_INDEX_W = 8;
    localparam int BEAT_FIELD_W = 16;

    typedef struct packed {
        logic [BEAT_INDEX_W-1:0] index;
        logic                    hit;
        logic [BEAT_FIELD_W-1:0] x;
        logic [BEAT_FIELD_W-1:0] y;
        logic [BEAT_FIELD_W-1:0] diameter;
    } target_beat_t;

endpackage

// File: rtl/target_stream_tx.sv
// rtl/target_stream_tx.sv - shadow buffer and valid/ready beat streamer for per-target results
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   capture_in, frame_id_in   snapshot request and the frame number to attach
//   xcount_in .. valid_in     flattened per-target datapath results
//   busy_out                  a frame is being streamed; captures are refused
//   tgt_*_out, tgt_ready_in   beat stream, one target per beat
//   frame_id_out              frame number of the buffered snapshot
module target_stream_tx
    import marker_pkg::*;
#(
    parameter  int NUM_TARGETS = 4,
    parameter  int XW          = 11,
    parameter  int YW          = 11,
    localparam int IW          = $clog2(NUM_TARGETS)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     capture_in,
    input  logic [7:0]               frame_id_in,
    input  logic [NUM_TARGETS*XW-1:0] xcount_in,
    input  logic [NUM_TARGETS*YW-1:0] ycount_in,
    input  logic [NUM_TARGETS*YW-1:0] diameter_in,
    input  logic [NUM_TARGETS-1:0]   valid_in,
    output logic                     busy_out,
    output logic                     tgt_valid_out,
    input  logic                     tgt_ready_in,
    output logic [IW-1:0]            tgt_index_out,
    output logic                     tgt_hit_out,
    output logic [XW-1:0]            tgt_x_out,
    output logic [YW-1:0]            tgt_y_out,
    output logic [YW-1:0]            tgt_diameter_out,
    output logic                     tgt_last_out,
    output logic [7:0]               frame_id_out
);

    logic                      active_q;
    logic [IW-1:0]             idx_q;
    logic [NUM_TARGETS*XW-1:0] x_buf_q;
    logic [NUM_TARGETS*YW-1:0] y_buf_q;
    logic [NUM_TARGETS*YW-1:0] d_buf_q;
    logic [NUM_TARGETS-1:0]    hit_buf_q;
    logic [7:0]                frame_id_q;

    logic         load;
    logic         accept;
    target_beat_t beat;

    // A capture arriving while any beat is still pending (including the
    // final beat being accepted this cycle) is refused.
    assign load   = capture_in & ~active_q;
    assign accept = active_q & tgt_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q   <= 1'b0;
            idx_q      <= '0;
            x_buf_q    <= '0;
            y_buf_q    <= '0;
            d_buf_q    <= '0;
            hit_buf_q  <= '0;
            frame_id_q <= '0;
        end else if (load) begin
            active_q   <= 1'b1;
            idx_q      <= '0;
            x_buf_q    <= xcount_in;
            y_buf_q    <= ycount_in;
            d_buf_q    <= diameter_in;
            hit_buf_q  <= valid_in;
            frame_id_q <= frame_id_in;
        end else if (accept) begin
            // Index wraps to 0 after the last beat since NUM_TARGETS is a power of two.
            idx_q <= idx_q + 1'b1;
            if (idx_q == IW'(NUM_TARGETS - 1)) begin
                active_q <= 1'b0;
            end
        end
    end

    always_comb begin
        beat          = '0;
        beat.index    = BEAT_INDEX_W'(idx_q);
        beat.hit      = hit_buf_q[idx_q];
        beat.x        = BEAT_FIELD_W'(x_buf_q[int'(idx_q)*XW +: XW]);
        beat.y        = BEAT_FIELD_W'(y_buf_q[int'(idx_q)*YW +: YW]);
        beat.diameter = BEAT_FIELD_W'(d_buf_q[int'(idx_q)*YW +: YW]);
    end

    assign busy_out         = active_q;
    assign tgt_valid_out    = active_q;
    assign tgt_index_out    = IW'(beat.index);
    assign tgt_hit_out      = beat.hit;
    assign tgt_x_out        = XW'(beat.x);
    assign tgt_y_out        = YW'(beat.y);
    assign tgt_diameter_out = YW'(beat.diameter);
    assign tgt_last_out     = active_q & (idx_q == IW'(NUM_TARGETS - 1));
    assign frame_id_out     = frame_id_q;

endmodule

// File: rtl/marker_frame_sequencer.sv
// rtl/marker_frame_sequencer.sv - frame boundary decode, datapath reset, settle and snapshot control
//
// Ports:
//   clk_in, rst_n_in              pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in          pixel counters
//   frame_start_out               one-cycle datapath reset pulse after each frame start
//   xcount_in .. valid_in         per-target datapath results
//   tgt_*                         per-target beat stream (valid/ready)
//   frame_id_out                  frame number of the streamed snapshot
//   overrun_out                   sticky: a snapshot was dropped
module marker_frame_sequencer
    import marker_pkg::*;
#(
    parameter  int NUM_TARGETS   = 4,
    parameter  int SCREEN_WIDTH  = 1280,
    parameter  int SCREEN_HEIGHT = 720,
    parameter  int SETTLE_CYCLES = 4,
    localparam int XW            = calc_xw(SCREEN_WIDTH),
    localparam int YW            = calc_yw(SCREEN_HEIGHT),
    localparam int IW            = $clog2(NUM_TARGETS)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [XW-1:0]             hcount_in,
    input  logic [YW-1:0]             vcount_in,
    output logic                      frame_start_out,
    input  logic [NUM_TARGETS*XW-1:0] xcount_in,
    input  logic [NUM_TARGETS*YW-1:0] ycount_in,
    input  logic [NUM_TARGETS*YW-1:0] diameter_in,
    input  logic [NUM_TARGETS-1:0]    valid_in,
    output logic                      tgt_valid_out,
    input  logic                      tgt_ready_in,
    output logic [IW-1:0]             tgt_index_out,
    output logic                      tgt_hit_out,
    output logic [XW-1:0]             tgt_x_out,
    output logic [YW-1:0]             tgt_y_out,
    output logic [YW-1:0]             tgt_diameter_out,
    output logic                      tgt_last_out,
    output logic [7:0]                frame_id_out,
    output logic                      overrun_out
);

    acq_state_e    state_q, state_d;
    logic [7:0]    settle_q, settle_d;
    logic [7:0]    frame_cnt_q;
    logic          overrun_q;
    logic          frame_start_q;
    logic [XW-1:0] hcount_prev_q;
    logic [YW-1:0] vcount_prev_q;

    logic at_origin, was_origin, at_end, was_end;
    logic start_ev, end_ev;
    logic capture;
    logic stream_busy;

    // Boundary events fire only on the cycle the counters arrive at the
    // position, so counters parked there produce a single event.
    assign at_origin  = (hcount_in == '0) && (vcount_in == '0);
    assign was_origin = (hcount_prev_q == '0) && (vcount_prev_q == '0);
    assign at_end     = (hcount_in == XW'(SCREEN_WIDTH - 1)) && (vcount_in == YW'(SCREEN_HEIGHT - 1));
    assign was_end    = (hcount_prev_q == XW'(SCREEN_WIDTH - 1)) && (vcount_prev_q == YW'(SCREEN_HEIGHT - 1));
    assign start_ev   = at_origin & ~was_origin;
    assign end_ev     = at_end & ~was_end;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            hcount_prev_q <= '0;
            vcount_prev_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            hcount_prev_q <= hcount_in;
            vcount_prev_q <= vcount_in;
            frame_start_q <= start_ev;
        end
    end

    // SNAPSHOT is reached SETTLE_CYCLES after the end event: the counter
    // holds SETTLE_CYCLES on the first SETTLE cycle and SNAPSHOT follows the
    // cycle it reads 2. A new frame start cuts the wait short so capture
    // happens before the datapath reset pulse lands.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (!start_ev && end_ev) begin
                    settle_d = 8'(SETTLE_CYCLES);
                    state_d  = (SETTLE_CYCLES == 1) ? ST_SNAPSHOT : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 8'd1;
                if (start_ev || settle_q <= 8'd2) state_d = ST_SNAPSHOT;
            end
            ST_SNAPSHOT: begin
                state_d = ST_ACQUIRE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        capture = (state_q == ST_SNAPSHOT);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else if (capture) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            if (stream_busy) overrun_q <= 1'b1;
        end
    end

    target_stream_tx #(
        .NUM_TARGETS (NUM_TARGETS),
        .XW          (XW),
        .YW          (YW)
    ) u_stream (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .capture_in       (capture),
        .frame_id_in      (frame_cnt_q + 8'd1),
        .xcount_in        (xcount_in),
        .ycount_in        (ycount_in),
        .diameter_in      (diameter_in),
        .valid_in         (valid_in),
        .busy_out         (stream_busy),
        .tgt_valid_out    (tgt_valid_out),
        .tgt_ready_in     (tgt_ready_in),
        .tgt_index_out    (tgt_index_out),
        .tgt_hit_out      (tgt_hit_out),
        .tgt_x_out        (tgt_x_out),
        .tgt_y_out        (tgt_y_out),
        .tgt_diameter_out (tgt_diameter_out),
        .tgt_last_out     (tgt_last_out),
        .frame_id_out     (frame_id_out)
    );

    assign frame_start_out = frame_start_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_marker_frame_sequencer.sv
// tb/tb_marker_frame_sequencer.sv - self-checking bench for marker_frame_sequencer
module tb_marker_frame_sequencer;

    localparam int N  = 4;
    localparam int W  = 1280;
    localparam int H  = 720;
    localparam int S  = 4;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [XW-1:0]   hcount;
    logic [YW-1:0]   vcount;
    logic [N*XW-1:0] xcount;
    logic [N*YW-1:0] ycount;
    logic [N*YW-1:0] diam;
    logic [N-1:0]    vin;
    logic            ready;

    logic            frame_start;
    logic            tgt_valid;
    logic [IW-1:0]   tgt_index;
    logic            tgt_hit;
    logic [XW-1:0]   tgt_x;
    logic [YW-1:0]   tgt_y;
    logic [YW-1:0]   tgt_d;
    logic            tgt_last;
    logic [7:0]      frame_id;
    logic            overrun;

    marker_frame_sequencer #(
        .NUM_TARGETS   (N),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .hcount_in        (hcount),
        .vcount_in        (vcount),
        .frame_start_out  (frame_start),
        .xcount_in        (xcount),
        .ycount_in        (ycount),
        .diameter_in      (diam),
        .valid_in         (vin),
        .tgt_valid_out    (tgt_valid),
        .tgt_ready_in     (ready),
        .tgt_index_out    (tgt_index),
        .tgt_hit_out      (tgt_hit),
        .tgt_x_out        (tgt_x),
        .tgt_y_out        (tgt_y),
        .tgt_diameter_out (tgt_d),
        .tgt_last_out     (tgt_last),
        .frame_id_out     (frame_id),
        .overrun_out      (overrun)
    );

    typedef struct {
        int idx;
        bit hit;
        int x;
        int y;
        int d;
        int fid;
    } beat_t;

    // Reference model: beats still owed to the consumer, plus a schedule of
    // the cycle at which the next snapshot is due.
    beat_t q[$];
    int    n_cmp   = 0;
    int    n_fail  = 0;
    int    cyc_n   = 0;
    int    phase   = 0;   // 0 waiting for first frame, 1 in frame, 2 waiting for results
    int    snap_at = -1;
    int    fcnt    = 0;
    int    rpol    = 0;   // 0 ready high, 1 random, 2 ready low
    bit    ovr     = 1'b0;
    bit    pin_valid = 1'b0;
    int    prev_h  = 100;
    int    prev_v  = 100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_valid"}, tgt_valid, 0);
        chk({tag, "_index"}, tgt_index, 0);
        chk({tag, "_hit"}, tgt_hit, 0);
        chk({tag, "_x"}, tgt_x, 0);
        chk({tag, "_y"}, tgt_y, 0);
        chk({tag, "_diameter"}, tgt_d, 0);
        chk({tag, "_last"}, tgt_last, 0);
        chk({tag, "_frame_id"}, frame_id, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic model_reset();
        q.delete();
        phase   = 0;
        snap_at = -1;
        fcnt    = 0;
        ovr     = 1'b0;
        prev_h  = int'(hcount);
        prev_v  = int'(vcount);
    endtask

    // One clock: apply the spec's rules to the inputs present now, let the
    // DUT take the edge, then compare every output against the model.
    task automatic tick();
        bit    st, en, snap_now, busy;
        beat_t b;
        st = (hcount == 0 && vcount == 0) && !(prev_h == 0 && prev_v == 0);
        en = (hcount == W-1 && vcount == H-1) && !(prev_h == W-1 && prev_v == H-1);
        prev_h = int'(hcount);
        prev_v = int'(vcount);

        snap_now = (phase == 2 && snap_at == cyc_n);
        if (snap_now) begin
            phase = 1;
        end else if (phase == 2) begin
            if (st) snap_at = cyc_n + 1;
        end else if (phase == 1) begin
            if (!st && en) begin
                phase   = 2;
                snap_at = cyc_n + S;
            end
        end else if (st) begin
            phase = 1;
        end

        busy = (q.size() != 0);
        if (snap_now) begin
            fcnt = (fcnt + 1) % 256;
            if (busy) begin
                ovr = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    b.idx = i;
                    b.hit = vin[i];
                    b.x   = int'(xcount[i*XW +: XW]);
                    b.y   = int'(ycount[i*YW +: YW]);
                    b.d   = int'(diam[i*YW +: YW]);
                    b.fid = fcnt;
                    q.push_back(b);
                end
            end
        end
        if (busy && ready) q.delete(0);

        @(posedge clk);
        #1;
        cyc_n++;
        chk("frame_start", frame_start, st);
        chk("tgt_valid", tgt_valid, q.size() != 0);
        chk("overrun", overrun, ovr);
        if (q.size() != 0) begin
            chk("tgt_index", tgt_index, q[0].idx);
            chk("tgt_hit", tgt_hit, q[0].hit);
            chk("tgt_x", tgt_x, q[0].x);
            chk("tgt_y", tgt_y, q[0].y);
            chk("tgt_diameter", tgt_d, q[0].d);
            chk("tgt_last", tgt_last, q[0].idx == N-1);
            chk("frame_id", frame_id, q[0].fid);
        end
    endtask

    task automatic run(input int n, input int h, input int v);
        for (int k = 0; k < n; k++) begin
            hcount = XW'(h);
            vcount = YW'(v);
            for (int i = 0; i < N; i++) begin
                xcount[i*XW +: XW] = XW'($urandom);
                ycount[i*YW +: YW] = YW'($urandom);
                diam[i*YW +: YW]   = YW'($urandom);
            end
            vin   = pin_valid ? 4'b0101 : N'($urandom);
            ready = (rpol == 0) ? 1'b1 : (rpol == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic frame(input int fill);
        run(2, 0, 0);
        run(fill, 300, 400);
        run(2, W-1, H-1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            run(1, 500, 600);
            k++;
        end
        chk("drain_idle", tgt_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        hcount = 11'd100;
        vcount = 11'd100;
        xcount = '0;
        ycount = '0;
        diam   = '0;
        vin    = '0;
        ready  = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        model_reset();
        rst_n = 1'b1;

        // Two frames, ready high, fixed hit pattern on the first.
        rpol = 0;
        run(3, 100, 100);
        pin_valid = 1'b1;
        frame(10);
        run(12, 500, 600);
        pin_valid = 1'b0;
        frame(7);
        run(12, 500, 600);

        // Random backpressure with a 50-cycle stall.
        rpol = 1;
        frame(5);
        run(6, 500, 600);
        rpol = 2;
        run(50, 500, 600);
        rpol = 1;
        drain();

        // Ready low across the next end event: second snapshot is dropped.
        rpol = 2;
        frame(5);
        run(8, 500, 600);
        frame(5);
        run(8, 500, 600);
        rpol = 0;
        drain();
        frame(5);
        run(10, 500, 600);

        // Frame start two cycles after the end event cuts the settle short.
        run(2, 0, 0);
        run(6, 300, 400);
        run(1, W-1, H-1);
        run(1, 500, 600);
        run(2, 0, 0);
        run(12, 300, 400);

        // Restart inside a frame: only the final end event yields a snapshot.
        run(2, 0, 0);
        run(4, 300, 400);
        run(1, 0, 0);
        run(4, 300, 400);
        run(1, W-1, H-1);
        run(12, 500, 600);

        // Reset asserted while beat 2 is on the bus.
        frame(5);
        k = 0;
        while (!(q.size() != 0 && q[0].idx == 2) && k < 50) begin
            run(1, 500, 600);
            k++;
        end
        chk("beat2_reached", tgt_index, 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("held_reset");
        model_reset();
        rst_n = 1'b1;
        run(3, 500, 600);
        run(1, W-1, H-1);
        run(12, 500, 600);
        frame(6);
        run(12, 500, 600);

        // Randomised frames, some close enough to preempt the settle wait.
        for (int f = 0; f < 10; f++) begin
            rpol = $urandom_range(0, 1);
            run($urandom_range(1, 3), 0, 0);
            run($urandom_range(1, 20), 300 + f, 400);
            run($urandom_range(1, 2), W-1, H-1);
            run($urandom_range(1, 12), 500, 600);
        end
        rpol = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
